// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_pkg
// Description : State encodings and default width for the bit-serial
//               subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_subtractor_pkg;

    localparam int c_default_width = 8;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

endpackage : serial_subtractor_pkg
`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : full_subtractor
// Description : One-bit combinational full subtractor (D = A - B - Bin).
// Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    logic w_axb;

    assign w_axb = A ^ B;
    assign D     = w_axb ^ Bin;
    assign Bout  = (~A & B) | (~w_axb & Bin);

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial WIDTH-bit subtractor, LSB first, with a
//               start/ready/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V
);

    localparam int                c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_d;
    logic               r_br;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_bout;
    logic               r_v;
    logic               r_a_msb;
    logic               r_b_msb;

    logic               w_d;
    logic               w_bo;

    full_subtractor u_cell (
        .A    (r_a[0]),
        .B    (r_b[0]),
        .Bin  (r_br),
        .D    (w_d),
        .Bout (w_bo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
            r_a     <= '0;
            r_b     <= '0;
            r_d     <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_bout  <= 1'b0;
            r_v     <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_br    <= Bin;
                        r_cnt   <= '0;
                        r_a_msb <= A[WIDTH-1];
                        r_b_msb <= B[WIDTH-1];
                        r_bout  <= 1'b0;
                        r_v     <= 1'b0;
                        r_state <= c_run;
                    end
                end
                c_run: begin
                    // Result bits enter at the MSB so the first (LSB) bit lands at bit 0.
                    r_d  <= {w_d, r_d[WIDTH-1:1]};
                    r_a  <= r_a >> 1;
                    r_b  <= r_b >> 1;
                    r_br <= w_bo;
                    if (r_cnt == c_last) begin
                        r_cnt   <= '0;
                        r_bout  <= w_bo;
                        // w_d here is the result MSB.
                        r_v     <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
                        r_state <= c_done;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_done: begin
                    r_state <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign ready = (r_state == c_idle);
    assign done  = (r_state == c_done);
    assign D     = r_d;
    assign Bout  = r_bout;
    assign V     = r_v;

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Directed self-checking bench for serial_subtractor (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;
    import serial_subtractor_pkg::*;

    localparam int c_w = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [c_w-1:0] A;
    logic [c_w-1:0] B;
    logic           Bin;
    logic           ready;
    logic           done;
    logic [c_w-1:0] D;
    logic           Bout;
    logic           V;

    int checks;
    int errors;

    serial_subtractor #(.WIDTH(c_w)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .ready (ready),
        .done  (done),
        .D     (D),
        .Bout  (Bout),
        .V     (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one operation and returns how many cycles after acceptance done
    // was seen (0 if it never came). Operand inputs are scrambled after
    // acceptance to show they are no longer needed.
    task automatic issue(input logic [c_w-1:0] a, input logic [c_w-1:0] b,
                         input logic bin, output int lat);
        @(negedge clk);
        A = a; B = b; Bin = bin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; A = ~a; B = ~b; Bin = ~bin;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || D !== 8'h00 || Bout !== 1'b0 || V !== 1'b0) begin
            errors++;
            $display("FAIL reset: ready=%b done=%b D=%h Bout=%b V=%b, want 1 0 00 0 0",
                     ready, done, D, Bout, V);
        end
    endtask

    task automatic test_basic();
        int lat;
        issue(8'h05, 8'h03, 1'b0, lat);
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL basic_latency: got %0d, want 9", lat);
        end
        checks++;
        if (D !== 8'h02 || Bout !== 1'b0 || V !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: D=%h Bout=%b V=%b, want 02 0 0", D, Bout, V);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || ready !== 1'b1 || D !== 8'h02) begin
            errors++;
            $display("FAIL basic_after: done=%b ready=%b D=%h, want 0 1 02", done, ready, D);
        end
    endtask

    task automatic test_borrow();
        int lat;
        issue(8'h00, 8'h01, 1'b0, lat);
        checks++;
        if (lat !== 9 || D !== 8'hFF || Bout !== 1'b1 || V !== 1'b0) begin
            errors++;
            $display("FAIL borrow_00_01: lat=%0d D=%h Bout=%b V=%b, want 9 FF 1 0", lat, D, Bout, V);
        end
        issue(8'h10, 8'h0F, 1'b1, lat);
        checks++;
        if (lat !== 9 || D !== 8'h00 || Bout !== 1'b0 || V !== 1'b0) begin
            errors++;
            $display("FAIL borrow_10_0F_bin: lat=%0d D=%h Bout=%b V=%b, want 9 00 0 0", lat, D, Bout, V);
        end
        issue(8'h5A, 8'h5A, 1'b1, lat);
        checks++;
        if (lat !== 9 || D !== 8'hFF || Bout !== 1'b1 || V !== 1'b0) begin
            errors++;
            $display("FAIL equal_bin: lat=%0d D=%h Bout=%b V=%b, want 9 FF 1 0", lat, D, Bout, V);
        end
    endtask

    task automatic test_overflow();
        int lat;
        issue(8'h80, 8'h01, 1'b0, lat);
        checks++;
        if (lat !== 9 || D !== 8'h7F || Bout !== 1'b0 || V !== 1'b1) begin
            errors++;
            $display("FAIL ovf_80_01: lat=%0d D=%h Bout=%b V=%b, want 9 7F 0 1", lat, D, Bout, V);
        end
        issue(8'h7F, 8'hFF, 1'b0, lat);
        checks++;
        if (lat !== 9 || D !== 8'h80 || Bout !== 1'b1 || V !== 1'b1) begin
            errors++;
            $display("FAIL ovf_7F_FF: lat=%0d D=%h Bout=%b V=%b, want 9 80 1 1", lat, D, Bout, V);
        end
    endtask

    task automatic test_ignored_start();
        int pulses;
        int done_at;
        @(negedge clk);
        A = 8'h09; B = 8'h04; Bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL ignore_ready_in_run: ready=%b, want 0", ready);
        end
        A = 8'h22; B = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        done_at = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (done_at == 0) begin
                    done_at = k;
                    checks++;
                    if (D !== 8'h05 || Bout !== 1'b0 || V !== 1'b0) begin
                        errors++;
                        $display("FAIL ignore_result: D=%h Bout=%b V=%b, want 05 0 0", D, Bout, V);
                    end
                end
            end
            if (done_at != 0 && k == done_at + 1) begin
                checks++;
                if (ready !== 1'b1) begin
                    errors++;
                    $display("FAIL ignore_ready_return: ready=%b, want 1", ready);
                end
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL ignore_pulses: got %0d done pulses, want 1", pulses);
        end
    endtask

    task automatic test_reset_midop();
        int lat;
        int stray;
        @(negedge clk);
        A = 8'h33; B = 8'h11; Bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || D !== 8'h00 || Bout !== 1'b0 || V !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: ready=%b done=%b D=%h Bout=%b V=%b, want 1 0 00 0 0",
                     ready, done, D, Bout, V);
        end
        stray = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL midop_no_done: got %0d done pulses, want 0", stray);
        end
        issue(8'h0A, 8'h0A, 1'b0, lat);
        checks++;
        if (lat !== 9 || D !== 8'h00 || Bout !== 1'b0) begin
            errors++;
            $display("FAIL midop_fresh: lat=%0d D=%h Bout=%b, want 9 00 0", lat, D, Bout);
        end
    endtask

    task automatic test_rst_start_priority();
        int busy;
        @(negedge clk);
        rst = 1'b1; start = 1'b1; A = 8'h05; B = 8'h03; Bin = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        busy = 0;
        repeat (12) begin
            @(negedge clk);
            if (ready !== 1'b1 || done !== 1'b0) busy++;
        end
        checks++;
        if (busy !== 0 || D !== 8'h00) begin
            errors++;
            $display("FAIL rst_start_priority: %0d busy cycles, D=%h, want 0 busy and 00", busy, D);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_borrow();
        test_overflow();
        test_ignored_start();
        test_reset_midop();
        test_rst_start_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_subtractor
`default_nettype wire
